// File: rtl/mem_access_seq.sv
// mem_access_seq: turns a one-cycle request into a timed BRAM access with per-direction wait states,
// holds the last read data and counts completed reads and writes.
module mem_access_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_mem_ena,
  output logic              mem_wr_ena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);
  localparam int MAX_WAIT = RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT;
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] RD_LAST = WC_W'(RD_WAIT - 1);
  localparam logic [WC_W-1:0] WR_LAST = WC_W'(WR_WAIT - 1);

  if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
    $fatal(1, "mem_access_seq: RD_WAIT and WR_WAIT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              accept, last;

  assign ready_o     = state_q != ACCESS;
  assign done_o      = state_q == DONE;
  assign mem_mem_ena = state_q == ACCESS;
  assign mem_wr_ena  = mem_mem_ena && we_q;
  assign mem_addr    = mem_mem_ena ? addr_q : '0;
  assign mem_wdata   = mem_mem_ena ? wdata_q : '0;
  assign rdata_o     = rdata_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

  // DONE also accepts a request so back-to-back accesses skip IDLE
  always_comb begin
    accept   = ready_o && req_i;
    last     = state_q == ACCESS && wcnt_q == (we_q ? WR_LAST : RD_LAST);
    state_d  = accept ? ACCESS : state_q == ACCESS ? (last ? DONE : ACCESS) : IDLE;
    wcnt_d   = accept ? '0 : state_q == ACCESS ? wcnt_q + WC_W'(1) : wcnt_q;
    we_d     = accept ? we_i : we_q;
    addr_d   = accept ? addr_i : addr_q;
    wdata_d  = accept ? wdata_i : wdata_q;
    rdata_d  = last && !we_q ? mem_rdata : rdata_q;
    rd_cnt_d = rd_cnt_q + CNT_W'(last && !we_q);
    wr_cnt_d = wr_cnt_q + CNT_W'(last && we_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wcnt_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wcnt_q   <= wcnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: three sequencer instances (default, slow, fast) each driving its own
// registered BRAM model; expectations come from a memory/counter model kept in the bench.
module tb_mem_access_seq;
  function automatic int rdw(int g);
    return g == 0 ? 3 : g == 1 ? 5 : 1;
  endfunction
  function automatic int wrw(int g);
    return g == 0 ? 1 : 3;
  endfunction
  function automatic int cntw(int g);
    return g == 0 ? 16 : 4;
  endfunction
  function automatic logic [15:0] init_val(int g, int k);
    return (g == 0 && k == 5) ? 16'h1234 : 16'((k * 40503) ^ (g * 4369) ^ 23130);
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req [3];
  logic        we [3];
  logic [15:0] addr [3];
  logic [15:0] wdata [3];
  logic        ready [3];
  logic        done [3];
  logic [15:0] rdata [3];
  logic        mem_ena [3];
  logic        mem_wr [3];
  logic [15:0] mem_addr [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic [15:0] rd_cnt [3];
  logic [15:0] wr_cnt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : h
    localparam int R = rdw(g);
    localparam int C = cntw(g);
    logic [C-1:0] rc, wc;
    logic [15:0]  bram [256];
    logic [15:0]  pipe [5];
    logic [15:0]  src;
    mem_access_seq #(.ADDR_W(16), .DATA_W(16), .RD_WAIT(R), .WR_WAIT(wrw(g)), .CNT_W(C)) u (
      .clk(clk), .reset_n(reset_n), .req_i(req[g]), .we_i(we[g]), .addr_i(addr[g]),
      .wdata_i(wdata[g]), .ready_o(ready[g]), .done_o(done[g]), .rdata_o(rdata[g]),
      .mem_mem_ena(mem_ena[g]), .mem_wr_ena(mem_wr[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .rd_cnt_o(rc), .wr_cnt_o(wc)
    );
    assign rd_cnt[g] = 16'(rc);
    assign wr_cnt[g] = 16'(wc);
    // read latency R-1 edges, so data is valid on the last enabled cycle
    assign src = mem_ena[g] ? bram[mem_addr[g][7:0]] : 16'hDEAD;
    assign mem_rdata[g] = R == 1 ? src : pipe[R > 1 ? R - 2 : 0];
    initial for (int k = 0; k < 256; k++) bram[k] = init_val(g, k);
    always @(posedge clk) begin
      pipe[0] <= src;
      for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
      if (mem_ena[g] && mem_wr[g]) bram[mem_addr[g][7:0]] <= mem_wdata[g];
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] ref_mem [3][256];
  int          exp_rd [3];
  int          exp_wr [3];
  logic [15:0] exp_rdata [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_done(input int i, input bit w, input logic [15:0] a, input logic [15:0] d);
    if (w) begin
      ref_mem[i][a[7:0]] = d;
      exp_wr[i] = (exp_wr[i] + 1) & ((1 << cntw(i)) - 1);
    end else begin
      exp_rdata[i] = ref_mem[i][a[7:0]];
      exp_rd[i] = (exp_rd[i] + 1) & ((1 << cntw(i)) - 1);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      exp_rd[i] = 0;
      exp_wr[i] = 0;
      exp_rdata[i] = '0;
    end
  endtask

  task automatic chk_done(input int i);
    chk("done_hi", done[i], 1'b1);
    chk("done_ready", ready[i], 1'b1);
    chk("done_ena", mem_ena[i], 1'b0);
    chk("done_addr", mem_addr[i], 16'h0);
    chk("rdata", rdata[i], exp_rdata[i]);
    chk("rd_cnt", rd_cnt[i], exp_rd[i]);
    chk("wr_cnt", wr_cnt[i], exp_wr[i]);
  endtask

  task automatic access(input int i, input bit w, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = w ? wrw(i) : rdw(i);
    chk("pre_ready", ready[i], 1'b1);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    tick();
    req[i] = 1'b0; we[i] = 1'($urandom); addr[i] = 16'($urandom); wdata[i] = 16'($urandom);
    for (int c = 0; c < n; c++) begin
      chk("acc_ena", mem_ena[i], 1'b1);
      chk("acc_wr", mem_wr[i], w);
      chk("acc_addr", mem_addr[i], a);
      chk("acc_wdata", mem_wdata[i], d);
      chk("acc_busy", {done[i], ready[i]}, 2'b00);
      tick();
    end
    model_done(i, w, a, d);
    chk_done(i);
    tick();
    chk("done_once", done[i], 1'b0);
    chk("idle_ena", mem_ena[i], 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      for (int k = 0; k < 256; k++) ref_mem[i][k] = init_val(i, k);
    end
    model_reset();
    repeat (3) tick();
    @(negedge clk) reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", ready[i], 1'b1);
      chk("rst_done", done[i], 1'b0);
      chk("rst_mem", {mem_ena[i], mem_wr[i], mem_addr[i], mem_wdata[i]}, 34'h0);
      chk("rst_rdata", rdata[i], 16'h0);
      chk("rst_cnt", {rd_cnt[i], wr_cnt[i]}, 32'h0);
    end

    access(0, 1'b0, 16'h0005, 16'h0);
    chk("read_1234", rdata[0], 16'h1234);
    chk("read_cnt1", rd_cnt[0], 16'd1);
    access(0, 1'b1, 16'h0010, 16'hBEEF);
    chk("bram_beef", h[0].bram[16], 16'hBEEF);
    chk("wr_keep_rdata", rdata[0], 16'h1234);
    chk("wr_cnt1", wr_cnt[0], 16'd1);

    // back-to-back: request held through DONE of the read
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0005;
    tick();
    we[0] = 1'b1; addr[0] = 16'h0006; wdata[0] = 16'hA55A;
    for (int c = 0; c < 3; c++) begin
      chk("b2b_rd_addr", {mem_ena[0], mem_wr[0], mem_addr[0]}, {2'b10, 16'h0005});
      tick();
    end
    model_done(0, 1'b0, 16'h0005, 16'h0);
    chk_done(0);
    tick();
    req[0] = 1'b0;
    chk("b2b_no_idle", {mem_ena[0], mem_wr[0], mem_addr[0], done[0]}, {2'b11, 16'h0006, 1'b0});
    tick();
    model_done(0, 1'b1, 16'h0006, 16'hA55A);
    chk_done(0);
    tick();
    chk("b2b_end", {done[0], mem_ena[0]}, 2'b00);

    // busy ignore: request pulse during ACCESS is dropped
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0005;
    tick();
    addr[0] = 16'h0020;
    tick();
    req[0] = 1'b0;
    chk("busy_addr", mem_addr[0], 16'h0005);
    tick();
    chk("busy_addr2", mem_addr[0], 16'h0005);
    tick();
    model_done(0, 1'b0, 16'h0005, 16'h0);
    chk_done(0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("busy_quiet", {done[0], mem_ena[0]}, 2'b00);
    end

    // asynchronous reset in the second ACCESS cycle of a read
    access(0, 1'b1, 16'h0007, 16'h7777);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0005;
    tick();
    req[0] = 1'b0;
    tick();
    chk("pre_rst_ena", mem_ena[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ena", mem_ena[0], 1'b0);
    chk("arst_done", done[0], 1'b0);
    chk("arst_rdata", rdata[0], 16'h0);
    chk("arst_cnt", {rd_cnt[0], wr_cnt[0]}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("post_rst", {ready[0], done[0], mem_ena[0], rd_cnt[0]}, {3'b100, 16'h0});
    access(0, 1'b0, 16'h0007, 16'h0);
    chk("post_rst_read", rdata[0], 16'h7777);

    // CNT_W=4 wrap on the slow instance
    for (int k = 0; k < 16; k++) access(1, 1'b0, 16'($urandom_range(0, 255)), 16'h0);
    chk("rd_wrap", rd_cnt[1], 16'h0);

    for (int k = 0; k < 60; k++)
      access($urandom_range(0, 2), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised memory-access sequencer for the SLC-3 datapath.
- Replaces the hard-coded wait-state chains in the control FSM: the fetch read chain, the LDR read chain and the STR write chain.
- Control issues one request pulse and waits for `done_o`; the sequencer drives the synchronous BRAM (registered output) with a configurable number of wait cycles per direction and holds the read data.
- Also keeps read/write access counters for debug/LED display.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- RD_WAIT, 3, cycles `mem_mem_ena` is held for a read; read data is valid on the last of them; must be >= 1
- WR_WAIT, 1, cycles `mem_mem_ena` and `mem_wr_ena` are held for a write; must be >= 1
- CNT_W, 16, width of each access counter

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_i  in  1  access request, sampled when `ready_o`=1
- we_i  in  1  1=write, 0=read; sampled with `req_i`
- addr_i  in  ADDR_W  access address (from MAR)
- wdata_i  in  DATA_W  write data (from MDR)
- ready_o  out  1  sequencer can accept a request this cycle
- done_o  out  1  one-cycle pulse: access complete
- rdata_o  out  DATA_W  last read data, held until the next read completes
- mem_mem_ena  out  1  BRAM enable
- mem_wr_ena  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data (registered output)
- rd_cnt_o  out  CNT_W  completed reads since reset
- wr_cnt_o  out  CNT_W  completed writes since reset

Behaviour:
- Reset (async, `reset_n`=0), effective immediately, mid-access included:
  - state=IDLE, all counters 0, `rdata_o`=0, `done_o`=0.
  - `mem_mem_ena`=0, `mem_wr_ena`=0, `mem_addr`=0, `mem_wdata`=0.
  - `ready_o`=1 once `reset_n`=1; an aborted access is not counted.
- States:
  - IDLE: `ready_o`=1, mem outputs 0.
  - ACCESS: `ready_o`=0; `mem_mem_ena`=1; `mem_wr_ena`=`we_q`; `mem_addr`=`addr_q`; `mem_wdata`=`wdata_q`.
  - DONE: `done_o`=1, `ready_o`=1, mem enables 0.
- Accept: at a rising edge with `ready_o`=1 and `req_i`=1, latch `we_i`/`addr_i`/`wdata_i`, clear the wait counter and go to ACCESS. `req_i` is ignored while `ready_o`=0; no queueing, no error.
- ACCESS lasts exactly N cycles, N = RD_WAIT (read) or WR_WAIT (write). The wait counter increments each edge; at the edge where counter = N-1:
  - read: `rdata_o` <= `mem_rdata`, `rd_cnt_o`++
  - write: `wr_cnt_o`++
  - then go to DONE.
- DONE lasts one cycle:
  - `req_i`=1 in DONE is accepted (back-to-back, straight to ACCESS); otherwise go to IDLE.
  - `done_o` is never high for two consecutive cycles unless there are two distinct completed accesses.
- Latency: request accepted at edge k → `done_o` high during cycle k+N (after edge k+N), for N+1 cycles request-to-done inclusive.
- Throughput: one access per N+1 cycles.
- `rdata_o` is unchanged by writes and aborted reads.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Mem outputs are combinational from state and latched registers; no glitch-free guarantee is required beyond synchronous BRAM sampling.
- Parameter check: RD_WAIT=0 or WR_WAIT=0 is a fatal elaboration error.

Test Plan:
- Read, defaults: BRAM model with 2-cycle registered read, mem[0x0005]=0x1234; pulse `req_i` with `we_i`=0, `addr_i`=0x0005 → `mem_mem_ena` high exactly 3 cycles with `mem_addr`=0x0005; `done_o` 1 cycle, 4 cycles after accept; `rdata_o`=0x1234; `rd_cnt_o`=1.
- Write: `we_i`=1, `addr_i`=0x0010, `wdata_i`=0xBEEF → `mem_wr_ena`=`mem_mem_ena`=1 for 1 cycle; `done_o` 2 cycles after accept; mem[0x0010]=0xBEEF; `wr_cnt_o`=1; `rdata_o` unchanged.
- Back-to-back: hold `req_i`=1 with read 0x0005 then write 0x0006 → the second request is accepted in DONE of the first, with no IDLE cycle; exactly two `done_o` pulses; counters rd=1, wr=1.
- Busy ignore: pulse `req_i` (`addr_i`=0x0020) during ACCESS of the read at 0x0005 → no additional access; `mem_addr` stays 0x0005; only one `done_o`.
- Reset mid-read: assert `reset_n`=0 in the 2nd ACCESS cycle (asynchronously, between edges) → `mem_mem_ena` drops in that same cycle; no `done_o`; `rd_cnt_o`=0; `rdata_o`=0; after release a new read completes normally.
- Parameter sweep: RD_WAIT=1 and 5, WR_WAIT=3 with a matching BRAM model → request-to-done = N+1 cycles each; 2^CNT_W reads with CNT_W=4 → `rd_cnt_o` wraps to 0.
